// File: rtl/interval_timer_if.sv
// Control/status bundle between the dispenser FSM and interval_timer.
// The master drives commands and target; the slave returns count, running and done.
interface interval_timer_if #(
  parameter int BIT_COUNT = 32
);
  logic                 start;
  logic                 stop;
  logic                 pause;
  logic                 auto_reload;
  logic [BIT_COUNT-1:0] target;
  logic [BIT_COUNT-1:0] count;
  logic                 running;
  logic                 done;

  modport master (
    output start, stop, pause, auto_reload, target,
    input  count, running, done
  );

  modport slave (
    input  start, stop, pause, auto_reload, target,
    output count, running, done
  );
endinterface

// File: rtl/interval_timer.sv
// Programmable interval timer: one-shot or auto-reload, with pause and abort.
// Optional tick prescaler enabled by defining COUNTER_PRESCALER_EN.
module interval_timer #(
  parameter int BIT_COUNT = 32,
  parameter int PRESCALE  = 50
) (
  input logic              clock,
  input logic              reset,
  interval_timer_if.slave  bus
);
  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t               r_state;
  state_t               w_state_n;
  logic [BIT_COUNT-1:0] r_count;
  logic [BIT_COUNT-1:0] w_count_n;
  logic [BIT_COUNT-1:0] r_target;
  logic [BIT_COUNT-1:0] w_target_n;
  logic [BIT_COUNT-1:0] w_inc;
  logic                 r_mode;
  logic                 w_mode_n;
  logic                 r_done;
  logic                 w_done_n;
  logic                 w_tick;

`ifdef COUNTER_PRESCALER_EN
  logic [31:0] r_presc;
  logic [31:0] w_presc_n;
`else
  logic        w_unused_prescale;
  assign w_unused_prescale = (PRESCALE >= 1);
`endif

  assign w_inc = r_count + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_target <= '0;
      r_mode   <= 1'b0;
      r_done   <= 1'b0;
`ifdef COUNTER_PRESCALER_EN
      r_presc  <= '0;
`endif
    end else begin
      r_state  <= w_state_n;
      r_count  <= w_count_n;
      r_target <= w_target_n;
      r_mode   <= w_mode_n;
      r_done   <= w_done_n;
`ifdef COUNTER_PRESCALER_EN
      r_presc  <= w_presc_n;
`endif
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_count_n  = r_count;
    w_target_n = r_target;
    w_mode_n   = r_mode;
    w_done_n   = 1'b0;
    w_tick     = 1'b0;
`ifdef COUNTER_PRESCALER_EN
    w_presc_n  = r_presc;
    if (r_state == S_RUN && !bus.pause) begin
      if (r_presc == 32'(PRESCALE - 1)) begin
        w_presc_n = '0;
        w_tick    = 1'b1;
      end else begin
        w_presc_n = r_presc + 32'd1;
      end
    end
`else
    w_tick = (r_state == S_RUN) && !bus.pause;
`endif

    if (bus.stop) begin
      w_state_n = S_IDLE;
`ifdef COUNTER_PRESCALER_EN
      w_presc_n = '0;
`endif
    end else if (bus.start) begin
      w_count_n  = '0;
      w_target_n = bus.target;
      w_mode_n   = bus.auto_reload;
      w_done_n   = (bus.target == '0);
      // A zero one-shot interval completes on the load cycle itself
      w_state_n  = (bus.target == '0 && !bus.auto_reload) ? S_IDLE : S_RUN;
`ifdef COUNTER_PRESCALER_EN
      w_presc_n  = '0;
`endif
    end else if (w_tick) begin
      if (r_count != r_target) begin
        w_count_n = w_inc;
        if (w_inc == r_target) begin
          w_done_n = 1'b1;
          if (!r_mode) w_state_n = S_IDLE;
        end
      end else begin
        w_count_n = '0;
        w_done_n  = (r_target == '0);
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.running = (r_state == S_RUN);
  assign bus.done    = r_done;
endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer (default build, no prescaler).
// Reference model tracks ticks elapsed in the interval and derives count arithmetically.
module tb_interval_timer;
  logic clock = 1'b0;
  logic reset;

  interval_timer_if #(.BIT_COUNT(32)) u_if ();

  interval_timer #(.BIT_COUNT(32), .PRESCALE(50)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  bit              m_run;
  bit              m_ar;
  bit              m_done;
  longint unsigned m_phase;
  longint unsigned m_T;
  logic [31:0]     m_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit rs, st, sp, pa, ar, input logic [31:0] tg);
    m_done = 1'b0;
    if (rs) begin
      m_run = 0; m_ar = 0; m_phase = 0; m_T = 0; m_count = 0;
    end else if (sp) begin
      m_run = 0;
    end else if (st) begin
      m_T     = longint'(tg);
      m_ar    = ar;
      m_phase = 0;
      m_count = 0;
      m_done  = (tg == 0);
      m_run   = !(tg == 0 && !ar);
    end else if (m_run && !pa) begin
      m_phase++;
      if (m_ar) begin
        m_count = 32'(m_phase % (m_T + 1));
        m_done  = (longint'(m_count) == m_T);
      end else begin
        m_count = 32'(m_phase);
        m_done  = (m_phase == m_T);
        if (m_done) m_run = 0;
      end
    end
  endtask

  task automatic step(input bit rs, st, sp, pa, ar, input logic [31:0] tg);
    reset             = rs;
    u_if.start        = st;
    u_if.stop         = sp;
    u_if.pause        = pa;
    u_if.auto_reload  = ar;
    u_if.target       = tg;
    @(posedge clock);
    model(rs, st, sp, pa, ar, tg);
    #1;
    chk("count",   u_if.count,         m_count);
    chk("running", 32'(u_if.running),  32'(m_run));
    chk("done",    32'(u_if.done),     32'(m_done));
  endtask

  task automatic idle(input int n, input bit pa = 1'b0);
    for (int i = 0; i < n; i++) step(0, 0, 0, pa, 0, 32'd99);
  endtask

  initial begin
    int done_cnt;
    reset = 1'b1;
    u_if.start = 0; u_if.stop = 0; u_if.pause = 0;
    u_if.auto_reload = 0; u_if.target = 0;
    @(negedge clock);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_count", u_if.count, 32'd0);

    // reset mid-count
    step(0, 1, 0, 0, 0, 32'd18);
    idle(5);
    step(1, 0, 0, 0, 0, 0);
    chk("midreset_count", u_if.count, 32'd0);
    chk("midreset_run",   32'(u_if.running), 32'd0);

    // one-shot to 18
    step(0, 1, 0, 0, 0, 32'd18);
    done_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      idle(1);
      if (u_if.done) done_cnt++;
    end
    chk("oneshot_end", u_if.count, 32'd18);
    chk("oneshot_done", 32'(u_if.done), 32'd1);
    chk("oneshot_ndone", 32'(done_cnt), 32'd1);
    idle(3);
    chk("oneshot_hold", u_if.count, 32'd18);

    // auto-reload period 4
    step(0, 1, 0, 0, 1, 32'd3);
    done_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      idle(1);
      if (u_if.done) done_cnt++;
    end
    chk("auto_ndone", 32'(done_cnt), 32'd3);
    step(0, 0, 1, 0, 0, 0);

    // pause at 5, stop at 7
    step(0, 1, 0, 0, 0, 32'd10);
    idle(5);
    idle(4, 1'b1);
    chk("pause_hold", u_if.count, 32'd5);
    idle(2);
    step(0, 0, 1, 0, 0, 0);
    chk("stop_count", u_if.count, 32'd7);
    idle(5);
    chk("stop_frozen", u_if.count, 32'd7);

    // target zero, one-shot and periodic
    step(0, 1, 0, 0, 0, 32'd0);
    chk("t0_done", 32'(u_if.done), 32'd1);
    idle(2);
    step(0, 1, 0, 0, 1, 32'd0);
    idle(3);
    chk("t0_auto_done", 32'(u_if.done), 32'd1);

    // restart at count 6, and start with pause held
    step(0, 1, 0, 0, 0, 32'd20);
    idle(6);
    step(0, 1, 0, 0, 0, 32'd9);
    chk("restart_count", u_if.count, 32'd0);
    step(0, 1, 0, 1, 0, 32'd4);
    idle(3, 1'b1);
    idle(6);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 25,
           1'($urandom),
           32'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
